// File: rtl/cache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// One 32-bit word per line; 4-state FSM for hit, write-back, refill.
module cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] cpu2cache_addr,
  input  logic [DATA_W-1:0] cpu2cache_data_in,
  input  logic              cpu2cache_rw,
  input  logic              cpu2cache_valid,
  output logic [DATA_W-1:0] cache2cpu_data_out,
  output logic              cache2cpu_ready,
  output logic [ADDR_W-1:0] cache2mem_addr,
  output logic [DATA_W-1:0] cache2mem_data_out,
  output logic              cache2mem_MemWrite,
  output logic              cache2mem_MemRead,
  input  logic [DATA_W-1:0] mem2cache_data_in,
  input  logic              mem2cache_ready
);

  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;
  localparam int LINES = 1 << IDX_W;
  localparam int LA_W  = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } state_t;

  state_t state, state_nx;

  logic [LA_W-1:0]   req_line;
  logic [DATA_W-1:0] req_data;
  logic              req_rw;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              victim_dirty;
  logic              unused_offset;

  assign unused_offset = ^cpu2cache_addr[OFFSET_W-1:0];

  assign idx          = req_line[IDX_W-1:0];
  assign req_tag      = req_line[LA_W-1:IDX_W];
  assign hit          = valid[idx] && (tag_mem[idx] == req_tag);
  assign victim_dirty = valid[idx] && dirty[idx];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (cpu2cache_valid) state_nx = COMPARE;
      COMPARE: begin
        if (hit)               state_nx = IDLE;
        else if (victim_dirty) state_nx = WRITE_BACK;
        else                   state_nx = ALLOCATE;
      end
      WRITE_BACK: if (mem2cache_ready) state_nx = ALLOCATE;
      ALLOCATE:   if (mem2cache_ready) state_nx = COMPARE;
      default:    state_nx = IDLE;
    endcase
  end

  // Memory-side outputs depend only on state and the captured request.
  always_comb begin
    cache2cpu_ready    = 1'b0;
    cache2mem_addr     = '0;
    cache2mem_data_out = '0;
    cache2mem_MemWrite = 1'b0;
    cache2mem_MemRead  = 1'b0;
    unique case (state)
      IDLE: cache2cpu_ready = 1'b1;
      WRITE_BACK: begin
        cache2mem_MemWrite = 1'b1;
        cache2mem_addr     = {tag_mem[idx], idx, {OFFSET_W{1'b0}}};
        cache2mem_data_out = data_mem[idx];
      end
      ALLOCATE: begin
        cache2mem_MemRead = 1'b1;
        cache2mem_addr    = {req_tag, idx, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST_n) begin
    if (iRST_n) begin
      state              <= IDLE;
      req_line           <= '0;
      req_data           <= '0;
      req_rw             <= 1'b0;
      valid              <= '0;
      dirty              <= '0;
      cache2cpu_data_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu2cache_valid) begin
        req_line <= cpu2cache_addr[ADDR_W-1:OFFSET_W];
        req_data <= cpu2cache_data_in;
        req_rw   <= cpu2cache_rw;
      end
      if (state == COMPARE && hit) begin
        if (req_rw) dirty[idx] <= 1'b1;
        else        cache2cpu_data_out <= data_mem[idx];
      end
      if (state == ALLOCATE && mem2cache_ready) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Array contents need no reset; the valid bits gate them.
  always_ff @(posedge iCLK) begin
    if (state == COMPARE && hit && req_rw)
      data_mem[idx] <= req_data;
    if (state == ALLOCATE && mem2cache_ready) begin
      data_mem[idx] <= mem2cache_data_in;
      tag_mem[idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a bench-side memory model.
// Tracks latency, memory handshakes and read data per request.
module tb_cache_controller;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic [31:0] cpu2cache_addr;
  logic [31:0] cpu2cache_data_in;
  logic        cpu2cache_rw;
  logic        cpu2cache_valid;
  logic [31:0] cache2cpu_data_out;
  logic        cache2cpu_ready;
  logic [31:0] cache2mem_addr;
  logic [31:0] cache2mem_data_out;
  logic        cache2mem_MemWrite;
  logic        cache2mem_MemRead;
  logic [31:0] mem2cache_data_in;
  logic        mem2cache_ready;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];
  int          edges, n_rd, n_wr;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic        timed_out, stall_bad, both_seen;

  cache_controller dut (
    .iCLK               (iCLK),
    .iRST_n             (iRST_n),
    .cpu2cache_addr     (cpu2cache_addr),
    .cpu2cache_data_in  (cpu2cache_data_in),
    .cpu2cache_rw       (cpu2cache_rw),
    .cpu2cache_valid    (cpu2cache_valid),
    .cache2cpu_data_out (cache2cpu_data_out),
    .cache2cpu_ready    (cache2cpu_ready),
    .cache2mem_addr     (cache2mem_addr),
    .cache2mem_data_out (cache2mem_data_out),
    .cache2mem_MemWrite (cache2mem_MemWrite),
    .cache2mem_MemRead  (cache2mem_MemRead),
    .mem2cache_data_in  (mem2cache_data_in),
    .mem2cache_ready    (mem2cache_ready)
  );

  always #5 iCLK = ~iCLK;

  // Issue one request and act as memory until ready returns.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d,
                         input logic rw, input int stall);
    int stall_left;
    logic done;
    @(negedge iCLK);
    cpu2cache_addr    = a;
    cpu2cache_data_in = d;
    cpu2cache_rw      = rw;
    cpu2cache_valid   = 1'b1;
    @(posedge iCLK);
    #1;
    cpu2cache_valid   = 1'b0;
    cpu2cache_addr    = 32'hdead_bee0;
    cpu2cache_data_in = 32'h5a5a_5a5a;
    cpu2cache_rw      = ~rw;
    edges = 1; n_rd = 0; n_wr = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    stall_bad = 1'b0;
    stall_left = stall;
    done = 1'b0;
    while (!done && edges < 60) begin
      if (cache2cpu_ready) begin
        done = 1'b1;
      end else begin
        if (cache2mem_MemRead && cache2mem_MemWrite) both_seen = 1'b1;
        mem2cache_ready = 1'b0;
        if (cache2mem_MemWrite) begin
          wr_addr = cache2mem_addr;
          wr_data = cache2mem_data_out;
          mem[cache2mem_addr[9:2]] = cache2mem_data_out;
          n_wr++;
          mem2cache_ready = 1'b1;
        end else if (cache2mem_MemRead) begin
          rd_addr = cache2mem_addr;
          if (stall_left > 0) begin
            stall_left--;
            if (cache2cpu_ready !== 1'b0) stall_bad = 1'b1;
          end else begin
            mem2cache_data_in = mem[cache2mem_addr[9:2]];
            mem2cache_ready = 1'b1;
            n_rd++;
          end
        end
        @(posedge iCLK);
        edges++;
        #1;
      end
    end
    mem2cache_ready = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset;
    tests++;
    if ({cache2cpu_ready, cache2mem_MemRead, cache2mem_MemWrite} !== 3'b100) begin
      fails++;
      $display("FAIL reset_strobes: rdy/rd/wr=%b want 100",
               {cache2cpu_ready, cache2mem_MemRead, cache2mem_MemWrite});
    end
    tests++;
    if (cache2cpu_data_out !== 32'h0 || cache2mem_addr !== 32'h0
        || cache2mem_data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: dout=%h maddr=%h mdata=%h want 0",
               cache2cpu_data_out, cache2mem_addr, cache2mem_data_out);
    end
  endtask

  task automatic test_write_miss;
    run_req(32'd4, 32'd5, 1'b1, 0);
    tests++;
    if (timed_out || edges != 4 || n_rd != 1 || rd_addr !== 32'd4 || n_wr != 0) begin
      fails++;
      $display("FAIL wmiss_4: to=%b edges=%0d rd=%0d@%h wr=%0d want 4,1@4,0",
               timed_out, edges, n_rd, rd_addr, n_wr);
    end
    tests++;
    if (cache2cpu_data_out !== 32'd0) begin
      fails++;
      $display("FAIL wmiss_dout: got %h want 0", cache2cpu_data_out);
    end
    run_req(32'd4, 32'd0, 1'b0, 0);
    tests++;
    if (timed_out || edges != 2 || n_rd != 0 || n_wr != 0
        || cache2cpu_data_out !== 32'd5) begin
      fails++;
      $display("FAIL rhit_4: edges=%0d rd=%0d wr=%0d data=%h want 2,0,0,5",
               edges, n_rd, n_wr, cache2cpu_data_out);
    end
  endtask

  task automatic test_second_line;
    run_req(32'd8, 32'd10, 1'b1, 0);
    tests++;
    if (timed_out || n_rd != 1 || rd_addr !== 32'd8 || n_wr != 0) begin
      fails++;
      $display("FAIL wmiss_8: rd=%0d@%h wr=%0d want 1@8,0", n_rd, rd_addr, n_wr);
    end
    run_req(32'd4, 32'd0, 1'b0, 0);
    tests++;
    if (n_rd != 0 || n_wr != 0 || cache2cpu_data_out !== 32'd5) begin
      fails++;
      $display("FAIL rd2_4: rd=%0d wr=%0d data=%h want 0,0,5",
               n_rd, n_wr, cache2cpu_data_out);
    end
    run_req(32'd8, 32'd0, 1'b0, 0);
    tests++;
    if (n_rd != 0 || n_wr != 0 || cache2cpu_data_out !== 32'd10) begin
      fails++;
      $display("FAIL rd2_8: rd=%0d wr=%0d data=%h want 0,0,a",
               n_rd, n_wr, cache2cpu_data_out);
    end
  endtask

  task automatic test_write_hit;
    run_req(32'd4, 32'd15, 1'b1, 0);
    tests++;
    if (timed_out || edges != 2 || n_rd != 0 || n_wr != 0
        || cache2cpu_data_out !== 32'd10) begin
      fails++;
      $display("FAIL whit_4: edges=%0d rd=%0d wr=%0d dout=%h want 2,0,0,a",
               edges, n_rd, n_wr, cache2cpu_data_out);
    end
    run_req(32'd4, 32'd0, 1'b0, 0);
    tests++;
    if (n_rd != 0 || n_wr != 0 || cache2cpu_data_out !== 32'd15) begin
      fails++;
      $display("FAIL whit_rd: rd=%0d wr=%0d data=%h want 0,0,f",
               n_rd, n_wr, cache2cpu_data_out);
    end
  endtask

  task automatic test_dirty_evict;
    run_req(32'd132, 32'd20, 1'b1, 0);
    tests++;
    if (timed_out || edges != 5 || n_wr != 1 || wr_addr !== 32'd4
        || wr_data !== 32'd15 || n_rd != 1 || rd_addr !== 32'd132) begin
      fails++;
      $display("FAIL evict_132: edges=%0d wr=%0d@%h=%h rd=%0d@%h want 5,1@4=f,1@84",
               edges, n_wr, wr_addr, wr_data, n_rd, rd_addr);
    end
    run_req(32'd132, 32'd0, 1'b0, 0);
    tests++;
    if (edges != 2 || n_rd != 0 || n_wr != 0 || cache2cpu_data_out !== 32'd20) begin
      fails++;
      $display("FAIL evict_rd132: edges=%0d rd=%0d wr=%0d data=%h want 2,0,0,14",
               edges, n_rd, n_wr, cache2cpu_data_out);
    end
    run_req(32'd4, 32'd0, 1'b0, 0);
    tests++;
    if (edges != 5 || n_wr != 1 || wr_addr !== 32'd132 || wr_data !== 32'd20
        || n_rd != 1 || rd_addr !== 32'd4 || cache2cpu_data_out !== 32'd15) begin
      fails++;
      $display("FAIL evict_rd4: edges=%0d wr=%0d@%h=%h rd=%0d@%h data=%h want 5,1@84=14,1@4,f",
               edges, n_wr, wr_addr, wr_data, n_rd, rd_addr, cache2cpu_data_out);
    end
  endtask

  task automatic test_stall;
    run_req(32'd12, 32'd0, 1'b0, 5);
    tests++;
    if (timed_out || edges != 9 || stall_bad || n_rd != 1 || rd_addr !== 32'd12) begin
      fails++;
      $display("FAIL stall_12: to=%b edges=%0d bad=%b rd=%0d@%h want 9,0,1@c",
               timed_out, edges, stall_bad, n_rd, rd_addr);
    end
    tests++;
    if (cache2cpu_data_out !== 32'd0) begin
      fails++;
      $display("FAIL stall_data: got %h want 0", cache2cpu_data_out);
    end
  endtask

  task automatic test_reset_mid_alloc;
    int waited;
    @(negedge iCLK);
    cpu2cache_addr  = 32'd260;
    cpu2cache_rw    = 1'b0;
    cpu2cache_valid = 1'b1;
    @(posedge iCLK);
    #1;
    cpu2cache_valid = 1'b0;
    mem2cache_ready = 1'b0;
    waited = 0;
    while (cache2mem_MemRead !== 1'b1 && waited < 10) begin
      @(posedge iCLK);
      #1;
      waited++;
    end
    tests++;
    if (cache2mem_MemRead !== 1'b1 || cache2mem_addr !== 32'd260) begin
      fails++;
      $display("FAIL alloc_260: rd=%b addr=%h want 1,104", cache2mem_MemRead, cache2mem_addr);
    end
    @(posedge iCLK);
    #3;
    iRST_n = 1'b1;
    #1;
    tests++;
    if ({cache2cpu_ready, cache2mem_MemRead, cache2mem_MemWrite} !== 3'b100
        || cache2mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: rdy/rd/wr=%b addr=%h want 100,0",
               {cache2cpu_ready, cache2mem_MemRead, cache2mem_MemWrite}, cache2mem_addr);
    end
    @(negedge iCLK);
    iRST_n = 1'b0;
    run_req(32'd4, 32'd0, 1'b0, 0);
    tests++;
    if (timed_out || edges != 4 || n_rd != 1 || rd_addr !== 32'd4 || n_wr != 0
        || cache2cpu_data_out !== 32'd15) begin
      fails++;
      $display("FAIL post_reset_4: edges=%0d rd=%0d@%h wr=%0d data=%h want 4,1@4,0,f",
               edges, n_rd, rd_addr, n_wr, cache2cpu_data_out);
    end
    // Line 2 was dirty at reset; its data never reached memory.
    run_req(32'd8, 32'd0, 1'b0, 0);
    tests++;
    if (n_rd != 1 || n_wr != 0 || cache2cpu_data_out !== 32'd0) begin
      fails++;
      $display("FAIL post_reset_8: rd=%0d wr=%0d data=%h want 1,0,0",
               n_rd, n_wr, cache2cpu_data_out);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    both_seen         = 1'b0;
    iRST_n            = 1'b1;
    cpu2cache_addr    = '0;
    cpu2cache_data_in = '0;
    cpu2cache_rw      = 1'b0;
    cpu2cache_valid   = 1'b0;
    mem2cache_data_in = '0;
    mem2cache_ready   = 1'b0;
    #2;
    test_reset;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b0;
    test_write_miss;
    test_second_line;
    test_write_hit;
    test_dirty_evict;
    test_stall;
    test_reset_mid_alloc;
    tests++;
    if (both_seen) begin
      fails++;
      $display("FAIL strobe_overlap: MemRead&MemWrite seen=%b want 0", both_seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
